// File: rtl/w4823_fir_filter_pkg.sv
// w4823_fir_filter_pkg: shared constants, number formats and sequencer states for the FIR filter
package w4823_fir_filter_pkg;
  localparam int NTAPS = 64;
  localparam int CAW = $clog2(NTAPS);
  localparam int H_SGN = 15;
  localparam int H_EXP_HI = 14;
  localparam int H_EXP_LO = 10;
  localparam int H_MAN_HI = 9;
  localparam int O_SGN = 28;
  localparam int O_EXP_HI = 27;
  localparam int O_EXP_LO = 22;
  localparam int O_MAN_HI = 21;
  localparam int O_BIAS = 52;
  // an FP16 value is sig11 * 2^(e - 25), so a product exponent is e1 + e2 - 50 + O_BIAS
  localparam int H_SIG_EXP = 25;
  localparam int PROD_EOFF = O_BIAS - 2 * H_SIG_EXP;
  typedef struct packed {
    logic s;
    logic [O_EXP_HI-O_EXP_LO:0] e;
    logic [O_MAN_HI:0] m;
  } fp29_t;
  typedef enum logic {S_IDLE, S_MAC} seq_t;
endpackage

// File: rtl/w4823_fir_filter_if.sv
// w4823_fir_filter_if: sample, coefficient and result signals of the FIR filter
interface w4823_fir_filter_if;
  import w4823_fir_filter_pkg::*;
  logic [H_SGN:0] din;
  logic valid_in;
  logic [H_SGN:0] cin;
  logic [CAW-1:0] caddr;
  logic cload;
  logic [O_SGN:0] dout_29i;
  logic valid;
  modport master (output din, valid_in, cin, caddr, cload, input dout_29i, valid);
  modport slave (input din, valid_in, cin, caddr, cload, output dout_29i, valid);
endinterface

// File: rtl/w4823_fir_filter_mac.sv
// fir_fp_mac: one FP16 x FP16 multiply folded into the 29-bit floating-point accumulator
module fir_fp_mac
  import w4823_fir_filter_pkg::*;
(
  input  logic [H_SGN:0] coef,
  input  logic [H_SGN:0] samp,
  input  fp29_t          acc,
  output fp29_t          acc_nx
);
  logic [21:0] p;
  logic [6:0] pe;
  logic zp;
  fp29_t prod, big, sml;
  logic swap;
  logic [5:0] d;
  logic [22:0] sum;
  logic [4:0] lz;
  assign p = 22'({1'b1, coef[H_MAN_HI:0]}) * 22'({1'b1, samp[H_MAN_HI:0]});
  assign pe = 7'(coef[H_EXP_HI:H_EXP_LO]) + 7'(samp[H_EXP_HI:H_EXP_LO]) + 7'(PROD_EOFF) - 7'(!p[21]);
  assign zp = coef[H_EXP_HI:H_EXP_LO] == '0 || samp[H_EXP_HI:H_EXP_LO] == '0;
  assign prod = zp ? 29'd0 : {coef[H_SGN] ^ samp[H_SGN], pe > 7'd63 ? 6'd63 : pe[5:0], p[21] ? p : {p[20:0], 1'b0}};
  // zero is all-zero, so it always loses the magnitude compare and aligns away to nothing
  assign swap = {prod.e, prod.m} > {acc.e, acc.m};
  assign big = swap ? prod : acc;
  assign sml = swap ? acc : prod;
  assign d = big.e - sml.e;
  assign sum = big.s == sml.s ? {1'b0, big.m} + {1'b0, sml.m >> d} : {1'b0, big.m} - {1'b0, sml.m >> d};
  // position of the leading one below the carry bit
  always_comb begin
    lz = '0;
    for (int i = 0; i < 22; i++) if (sum[i]) lz = 5'(21 - i);
  end
  assign acc_nx = sum[22] ? {big.s, big.e == 6'd63 ? 6'd63 : big.e + 6'd1, sum[22:1]} :
                  (sum == '0 || big.e < 6'(lz)) ? 29'd0 : {big.s, big.e - 6'(lz), sum[21:0] << lz};
endmodule

// File: rtl/w4823_fir_filter.sv
// w4823_fir_filter: 64-tap FP16 FIR, one serial MAC per clk_fast cycle per sample strobe
module w4823_fir_filter #(
  parameter int NTAPS = w4823_fir_filter_pkg::NTAPS
) (
  input logic clk_fast,
  input logic rst_n,
  input logic clk_slow,
  w4823_fir_filter_if.slave bus
);
  import w4823_fir_filter_pkg::*;
  localparam int AW = $clog2(NTAPS);
  logic [H_SGN:0] cmem [NTAPS];
  logic [H_SGN:0] x [NTAPS];
  logic slow_q, strobe, last, done;
  logic [AW-1:0] idx;
  fp29_t acc, acc_nx;
  seq_t state, state_nx;
  assign strobe = (clk_slow & ~slow_q) | bus.valid_in;
  assign last = idx == AW'(NTAPS - 1);
  fir_fp_mac u_mac (.coef(cmem[idx]), .samp(x[idx]), .acc(acc), .acc_nx(acc_nx));
  // coefficient writes land on the falling edge and are never reset
  always_ff @(negedge clk_fast) if (bus.cload) cmem[AW'(bus.caddr)] <= bus.cin;
  // sequencer state register
  always_ff @(posedge clk_fast or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // a strobe (re)starts the run; the last tap finishes it and publishes the result
  always_comb begin
    state_nx = state;
    done = 1'b0;
    if (strobe) state_nx = S_MAC;
    else if (state == S_MAC) begin
      done = last;
      state_nx = last ? S_IDLE : S_MAC;
    end
  end
  // edge detector, delay line, accumulator and output register
  always_ff @(posedge clk_fast or negedge rst_n)
    if (!rst_n) begin
      slow_q <= 1'b0;
      idx <= '0;
      acc <= '0;
      bus.dout_29i <= '0;
      bus.valid <= 1'b0;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else begin
      slow_q <= clk_slow;
      bus.valid <= done;
      if (done) bus.dout_29i <= acc_nx;
      if (strobe) begin
        x[0] <= bus.din;
        for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
        idx <= '0;
        acc <= '0;
      end else if (state == S_MAC) begin
        acc <= acc_nx;
        idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_w4823_fir_filter.sv
// tb_w4823_fir_filter: directed vectors with hand-computed FP results for the FIR filter
module tb_w4823_fir_filter;
  logic clk_fast = 1'b0;
  logic rst_n = 1'b0;
  logic clk_slow = 1'b0;
  int total = 0, bad = 0, pulses = 0, exp_pulses = 0, unstable = 0;
  logic [28:0] prev = '0, y;
  always #5 clk_fast = ~clk_fast;
  w4823_fir_filter_if bus ();
  w4823_fir_filter dut (.clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .bus(bus.slave));
  // count valid pulses and any output change not accompanied by one
  always @(negedge clk_fast)
    if (!rst_n) prev <= bus.dout_29i;
    else begin
      if (bus.valid) pulses <= pulses + 1;
      else if (bus.dout_29i !== prev) unstable <= unstable + 1;
      prev <= bus.dout_29i;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drv;
    @(posedge clk_fast);
    #2;
  endtask
  task automatic wr(input int a, input logic [15:0] v);
    drv();
    bus.caddr = 6'(a);
    bus.cin = v;
    bus.cload = 1'b1;
  endtask
  task automatic wr_end;
    drv();
    bus.cload = 1'b0;
  endtask
  task automatic load(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] rest);
    for (int i = 0; i < 64; i++) wr(i, i == 0 ? c0 : i == 1 ? c1 : rest);
    wr_end();
  endtask
  task automatic fire(input logic [15:0] d, input bit slow);
    drv();
    bus.din = d;
    if (slow) clk_slow = 1'b1;
    else bus.valid_in = 1'b1;
    drv();
    bus.valid_in = 1'b0;
  endtask
  task automatic sample(input logic [15:0] d, input bit slow, output logic [28:0] r);
    int n;
    fire(d, slow);
    n = 1;
    while (!bus.valid && n < 140) begin
      @(negedge clk_fast);
      n++;
    end
    chk("latency_ok", 32'(n <= 130), 1);
    exp_pulses++;
    r = bus.dout_29i;
    drv();
    clk_slow = 1'b0;
  endtask
  task automatic run(input int n, input logic [15:0] d, output logic [28:0] r);
    for (int i = 0; i < n; i++) sample(d, i[0], r);
  endtask
  initial begin
    bus.din = '0;
    bus.valid_in = 1'b0;
    bus.cin = '0;
    bus.caddr = '0;
    bus.cload = 1'b0;
    repeat (3) @(negedge clk_fast);
    chk("rst_dout", 32'(bus.dout_29i), 0);
    chk("rst_valid", 32'(bus.valid), 0);
    load(16'h3C00, 16'h3C00, 16'h3C00);
    drv();
    rst_n = 1'b1;
    run(1, 16'h3C00, y);
    chk("ones_first", 32'(y), 32'h07E00000);
    run(63, 16'h3C00, y);
    chk("ones_64", 32'(y), 32'h09600000);
    fire(16'h3C00, 1'b0);
    repeat (10) @(negedge clk_fast);
    chk("busy_no_valid", 32'(bus.valid), 0);
    drv();
    rst_n = 1'b0;
    @(negedge clk_fast);
    chk("midrst_dout", 32'(bus.dout_29i), 0);
    chk("midrst_valid", 32'(bus.valid), 0);
    repeat (3) drv();
    rst_n = 1'b1;
    repeat (80) @(negedge clk_fast);
    run(64, 16'h3C00, y);
    chk("ones_after_rst", 32'(y), 32'h09600000);
    run(64, 16'h0001, y);
    chk("subnormal", 32'(y), 0);
    load(16'h4000, 16'hBC00, 16'h0000);
    sample(16'h3C00, 1'b1, y);
    chk("imp_tap0", 32'(y), 32'h08200000);
    sample(16'h0000, 1'b0, y);
    chk("imp_tap1", 32'(y), 32'h17E00000);
    sample(16'h0000, 1'b1, y);
    chk("imp_tail0", 32'(y), 0);
    sample(16'h0000, 1'b0, y);
    chk("imp_tail1", 32'(y), 0);
    load(16'h3C00, 16'hB800, 16'h0000);
    sample(16'h3E00, 1'b0, y);
    chk("mix_1p5", 32'(y), 32'h07F00000);
    sample(16'h4000, 1'b1, y);
    chk("mix_1p25", 32'(y), 32'h07E80000);
    fire(16'h4000, 1'b0);
    repeat (10) @(negedge clk_fast);
    sample(16'h3C00, 1'b0, y);
    chk("restart_zero", 32'(y), 0);
    for (int i = 0; i < 64; i++) wr(i, i == 0 ? 16'h3C00 : 16'h0000);
    wr(0, 16'h4400);
    wr_end();
    sample(16'h3C00, 1'b1, y);
    chk("cmem_wrap", 32'(y), 32'h08600000);
    repeat (150) @(negedge clk_fast);
    chk("pulse_count", 32'(pulses), 32'(exp_pulses));
    chk("dout_stable", 32'(unstable), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
